// File: rtl/comm_pkg.sv
// Shared definitions for the module-communication serial link:
// transmitter state encoding and the frame-length helper that both the
// transmit and receive sides use to reason about frame timing.
package comm_pkg;

    // Transmitter states. Codes 5..7 are unused and recover to IDLE.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Clocks from the first start-bit cycle to the last stop cycle inclusive.
    function automatic int frame_cycles(input int data_w,
                                        input int parity_en,
                                        input int stop_bits,
                                        input int bit_cycles);
        return (1 + data_w + parity_en + stop_bits) * bit_cycles;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: a modulo-BIT_CYCLES counter that flags the last clock
// of every bit period. It free-runs so consecutive bits never drift; a
// clear realigns it so the next clock is the first of a new bit period.
module bit_timer #(
    parameter int BIT_CYCLES = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: realign on clear, wrap to zero at terminal count.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == LAST_CNT)) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST_CNT);

endmodule

// File: rtl/serial_tx.sv
// Serial link transmitter. Frames a parallel word as
//   start (~IDLE_LEVEL), DATA_W payload bits LSB first,
//   optional even parity, STOP_BITS stop bits (IDLE_LEVEL),
// holding every bit for BIT_CYCLES clocks on a registered line output.
// DATA_W must be 1..16, BIT_CYCLES >= 2, STOP_BITS 1 or 2.
// ready/done are combinational so a word offered during the last stop
// cycle is accepted and its start bit follows with no idle gap.
module serial_tx
    import comm_pkg::*;
#(
    parameter int   DATA_W     = 8,
    parameter int   BIT_CYCLES = 8,
    parameter int   PARITY_EN  = 0,
    parameter int   STOP_BITS  = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] data_in,
    input  logic              start,
    output logic              ready,
    output logic              done,
    output logic              out
);

    // Bit counter indexes payload bits in DATA and stop bits in STOP.
    localparam int BCNT_W = $clog2(DATA_W + 1);
    localparam logic [BCNT_W-1:0] LAST_DATA = BCNT_W'(DATA_W - 1);
    localparam logic [BCNT_W-1:0] LAST_STOP = BCNT_W'(STOP_BITS - 1);

    tx_state_e          state_q;
    tx_state_e          state_d;
    logic [BCNT_W-1:0]  bit_cnt_q;
    logic [BCNT_W-1:0]  bit_cnt_d;
    logic [DATA_W-1:0]  shift_q;
    logic [DATA_W-1:0]  shift_d;
    logic               parity_q;
    logic               parity_d;
    logic               out_q;
    logic               out_d;

    logic               tick;
    logic               frame_end;
    logic               accept;

    bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .CLK   (CLK),
        .RST   (RST),
        .clear (accept),
        .tick  (tick)
    );

    // Last clock of the last stop bit: the line is free from the next clock.
    assign frame_end = (state_q == STOP) && tick && (bit_cnt_q == LAST_STOP);
    assign ready     = (state_q == IDLE) || frame_end;
    assign done      = frame_end;
    assign accept    = start && ready;

    // Next-state, counter, shifter and line-level logic.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    // Present the next payload bit on bit 0.
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                shift_d   = '0;
                parity_d  = 1'b0;
            end
        endcase

        // A new word overrides whatever the frame logic decided.
        if (accept) begin
            state_d   = START;
            bit_cnt_d = '0;
            shift_d   = data_in;
            parity_d  = ^data_in;
        end

        // The line is registered, so drive the level of the state we enter.
        case (state_d)
            START:   out_d = ~IDLE_LEVEL;
            DATA:    out_d = shift_d[0];
            PARITY:  out_d = parity_d;
            default: out_d = IDLE_LEVEL;
        endcase
    end

    // State and datapath registers; reset forces the line idle at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            out_q     <= IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            out_q     <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances share stimulus (8N1 and 8E2). A
// frame-level model expands every accepted word into the per-clock line
// levels it must produce and is compared with both DUTs every cycle.
module tb_serial_tx;
    import comm_pkg::*;

    localparam int BC     = 8;
    localparam int TR_LEN = 16384;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready0, done0, out0;
    logic       ready1, done1, out1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic q0[$];
    logic q1[$];
    int   acc0_cyc[$];
    int   acc1_cyc[$];
    logic tr_out0 [TR_LEN];
    logic tr_rdy0 [TR_LEN];
    logic tr_don0 [TR_LEN];
    logic tr_out1 [TR_LEN];
    logic tr_don1 [TR_LEN];

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(8), .BIT_CYCLES(BC), .PARITY_EN(0), .STOP_BITS(1), .IDLE_LEVEL(1'b0)) dut0 (
        .CLK(clk), .RST(rst), .data_in(data_in), .start(start),
        .ready(ready0), .done(done0), .out(out0));

    serial_tx #(.DATA_W(8), .BIT_CYCLES(BC), .PARITY_EN(1), .STOP_BITS(2), .IDLE_LEVEL(1'b0)) dut1 (
        .CLK(clk), .RST(rst), .data_in(data_in), .start(start),
        .ready(ready1), .done(done1), .out(out1));

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Expand one word into line levels: start, data LSB first, parity, stops.
    task automatic push_frame(input int which, input logic [7:0] d);
        int   par   = (which == 1) ? 1 : 0;
        int   stops = (which == 1) ? 2 : 1;
        int   nbits = 1 + 8 + par + stops;
        logic lvl;
        for (int b = 0; b < nbits; b++) begin
            if (b == 0)                 lvl = 1'b1;
            else if (b <= 8)            lvl = d[b-1];
            else if (par == 1 && b == 9) lvl = ^d;
            else                        lvl = 1'b0;
            for (int c = 0; c < BC; c++) begin
                if (which == 0) q0.push_back(lvl);
                else            q1.push_back(lvl);
            end
        end
    endtask

    // Compare process: sample away from the rising edge, then advance the model.
    initial begin
        logic e_out0, e_rdy0, e_don0, e_out1, e_rdy1, e_don1;
        logic acc0, acc1;
        forever begin
            @(negedge clk);
            if (rst) begin
                q0.delete();
                q1.delete();
            end
            e_out0 = (q0.size() > 0) ? q0[0] : 1'b0;
            e_rdy0 = (q0.size() <= 1);
            e_don0 = (q0.size() == 1);
            e_out1 = (q1.size() > 0) ? q1[0] : 1'b0;
            e_rdy1 = (q1.size() <= 1);
            e_don1 = (q1.size() == 1);
            chk_bit("out0", out0, e_out0);
            chk_bit("ready0", ready0, e_rdy0);
            chk_bit("done0", done0, e_don0);
            chk_bit("out1", out1, e_out1);
            chk_bit("ready1", ready1, e_rdy1);
            chk_bit("done1", done1, e_don1);
            if (cyc < TR_LEN) begin
                tr_out0[cyc] = out0;
                tr_rdy0[cyc] = ready0;
                tr_don0[cyc] = done0;
                tr_out1[cyc] = out1;
                tr_don1[cyc] = done1;
            end
            acc0 = !rst && start && e_rdy0;
            acc1 = !rst && start && e_rdy1;
            if (q0.size() > 0) void'(q0.pop_front());
            if (q1.size() > 0) void'(q1.pop_front());
            if (acc0) begin
                push_frame(0, data_in);
                acc0_cyc.push_back(cyc);
                $display("accept inst=0 data=%02h cycle=%0d", data_in, cyc);
            end
            if (acc1) begin
                push_frame(1, data_in);
                acc1_cyc.push_back(cyc);
                $display("accept inst=1 data=%02h cycle=%0d", data_in, cyc);
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (!(ready0 && ready1 && !done0 && !done1) && n < limit) begin
            step();
            n++;
        end
        chk_bit("idle_reached", (n < limit), 1'b1);
    endtask

    task automatic step_until(input int target);
        int n = 0;
        while (cyc < target && n < 2000) begin
            step();
            n++;
        end
        chk_bit("step_until_reached", (cyc >= target), 1'b1);
    endtask

    // Issue a single-cycle start and return the sample index of acceptance.
    task automatic send_word(input logic [7:0] d, output int t);
        int n_before = acc0_cyc.size();
        data_in = d;
        start   = 1'b1;
        step();
        start   = 1'b0;
        chk_int("send_accepted", acc0_cyc.size() - n_before, 1);
        t = (acc0_cyc.size() > 0) ? acc0_cyc[$] : 0;
    endtask

    initial begin
        int         t, base, n0, n1, dcount;
        logic [7:0] pat;

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_bit("reset_out", out0, 1'b0);
        chk_bit("reset_ready", ready0, 1'b1);
        chk_bit("reset_done", done0, 1'b0);
        step();
        rst = 1'b0;
        step();

        // A5 single frame; payload changes while busy must not matter.
        send_word(8'hA5, t);
        base = t + 1;
        repeat (5) begin
            data_in = 8'($urandom);
            step();
        end
        step_until(base + 100);
        chk_bit("a5_ready_before", tr_rdy0[t], 1'b1);
        chk_bit("a5_ready_drop", tr_rdy0[t+1], 1'b0);
        chk_bit("a5_start_first", tr_out0[base], 1'b1);
        chk_bit("a5_start_last", tr_out0[base+7], 1'b1);
        pat = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            chk_bit("a5_bit_first", tr_out0[base+8+8*k], pat[k]);
            chk_bit("a5_bit_last", tr_out0[base+15+8*k], pat[k]);
        end
        chk_bit("a5_stop", tr_out0[base+72], 1'b0);
        chk_bit("a5_done_early", tr_don0[base+78], 1'b0);
        chk_bit("a5_done", tr_don0[base+79], 1'b1);
        chk_bit("a5_ready_at_done", tr_rdy0[base+79], 1'b1);
        chk_bit("a5_done_after", tr_don0[base+80], 1'b0);
        chk_bit("a5_parity", tr_out1[base+72], 1'b0);
        chk_bit("a5_8e2_done", tr_don1[base+95], 1'b1);

        // 07: odd popcount, parity bit 1 after bit 7 on the parity instance.
        wait_idle(200);
        send_word(8'h07, t);
        base = t + 1;
        step_until(base + 100);
        chk_bit("p07_bit7", tr_out1[base+71], 1'b0);
        chk_bit("p07_parity_first", tr_out1[base+72], 1'b1);
        chk_bit("p07_parity_last", tr_out1[base+79], 1'b1);
        chk_bit("p07_stop", tr_out1[base+80], 1'b0);
        chk_bit("p07_done_early", tr_don1[base+94], 1'b0);
        chk_bit("p07_done", tr_don1[base+95], 1'b1);
        chk_bit("p07_8n1_done", tr_don0[base+79], 1'b1);

        // start held high: 01 then FF back to back with no idle gap.
        wait_idle(200);
        n0 = acc0_cyc.size();
        data_in = 8'h01;
        start   = 1'b1;
        step();
        chk_int("held_first_accept", acc0_cyc.size() - n0, 1);
        t = (acc0_cyc.size() > 0) ? acc0_cyc[$] : 0;
        base = t + 1;
        data_in = 8'hFF;
        step_until(base + 162);
        start = 1'b0;
        dcount = 0;
        for (int i = 0; i < 160; i++) dcount += int'(tr_don0[base+i]);
        chk_int("held_done_count", dcount, 2);
        chk_bit("held_f1_bit0", tr_out0[base+8], 1'b1);
        chk_bit("held_f1_bit1", tr_out0[base+16], 1'b0);
        chk_bit("held_last_stop", tr_out0[base+79], 1'b0);
        chk_bit("held_done1", tr_don0[base+79], 1'b1);
        chk_bit("held_f2_start", tr_out0[base+80], 1'b1);
        chk_bit("held_f2_bit0", tr_out0[base+88], 1'b1);
        chk_bit("held_done2", tr_don0[base+159], 1'b1);
        wait_idle(400);

        // start pulsed mid-frame with 3C must be ignored.
        n0 = acc0_cyc.size();
        n1 = acc1_cyc.size();
        send_word(8'hA5, t);
        base = t + 1;
        step_until(base + 30);
        data_in = 8'h3C;
        start   = 1'b1;
        step();
        start   = 1'b0;
        step_until(base + 100);
        chk_int("ignored_acc0", acc0_cyc.size() - n0, 1);
        chk_int("ignored_acc1", acc1_cyc.size() - n1, 1);
        chk_bit("ignored_bit0", tr_out0[base+8], 1'b1);
        chk_bit("ignored_bit7", tr_out0[base+64], 1'b1);
        chk_bit("ignored_idle_after", tr_out0[base+85], 1'b0);

        // Asynchronous reset in the middle of DATA, then a clean 5A frame.
        wait_idle(200);
        send_word(8'h5A, t);
        base = t + 1;
        step_until(base + 19);
        chk_bit("prereset_out0", out0, 1'b1);
        chk_bit("prereset_out1", out1, 1'b1);
        rst = 1'b1;
        #1;
        chk_bit("async_out0", out0, 1'b0);
        chk_bit("async_ready0", ready0, 1'b1);
        chk_bit("async_done0", done0, 1'b0);
        chk_bit("async_out1", out1, 1'b0);
        chk_bit("async_ready1", ready1, 1'b1);
        step();
        step();
        rst = 1'b0;
        step();
        wait_idle(50);
        send_word(8'h5A, t);
        base = t + 1;
        step_until(base + 100);
        chk_bit("post_start", tr_out0[base], 1'b1);
        chk_bit("post_bit0", tr_out0[base+8], 1'b0);
        chk_bit("post_bit1", tr_out0[base+16], 1'b1);
        chk_bit("post_bit7", tr_out0[base+64], 1'b0);
        chk_bit("post_done", tr_don0[base+79], 1'b1);

        // Random traffic with occasional resets, checked by the model.
        for (int i = 0; i < 3000; i++) begin
            start   = ($urandom_range(0, 99) < 25);
            data_in = 8'($urandom);
            rst     = ($urandom_range(0, 699) == 0);
            step();
        end
        rst   = 1'b0;
        start = 1'b0;
        step();
        wait_idle(frame_cycles(8, 1, 2, BC) + 20);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
